// File: rtl/regfile_pkg.sv
// Shared register-file constants and the writeback request payload used by the
// register file and its writeback scheduler.
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Writeback channel: N_REQ requesters in, one register-file write port out.
interface regfile_wb_scheduler_if #(
  parameter int N_REQ = 3
);
  import regfile_pkg::*;

  // Handshake: requester i holds req_valid[i], its req_addr slice and its
  // req_data slice stable until req_ready[i] is seen high.  A transfer happens
  // in any cycle where req_valid[i] & req_ready[i]; req_ready is one-hot or
  // zero, and never high for a requester that is not valid.  The write port
  // (wr_*) has no ready and never stalls.
  logic [N_REQ-1:0]            req_valid;
  logic [REG_ADDR_W*N_REQ-1:0] req_addr;
  logic [XLEN*N_REQ-1:0]       req_data;
  logic [N_REQ-1:0]            req_ready;
  logic                        wr_ena;
  logic [REG_ADDR_W-1:0]       wr_addr;
  logic [XLEN-1:0]             wr_data;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, wr_ena, wr_addr, wr_data
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, wr_ena, wr_addr, wr_data
  );

endinterface

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last winner and wraps.
// The pointer moves only when the current grant is consumed (advance).
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int LG_W = (N > 1) ? $clog2(N) : 1;

  logic [LG_W-1:0] last_grant;
  logic [LG_W-1:0] gnt_idx;

  always_comb begin
    int  idx;
    logic found;
    gnt     = '0;
    gnt_idx = last_grant;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_grant) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = LG_W'(idx);
        found    = 1'b1;
      end
    end
  end

  // Reset to N-1 so that requester 0 is first in line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= LG_W'(N - 1);
    end else if (advance && (|gnt)) begin
      last_grant <= gnt_idx;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler: arbitrates requesters onto the single register-file
// write port and tracks per-register busy bits for RAW hazard detection.
module regfile_wb_scheduler
  import regfile_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rsv_valid,
  input  logic [REG_ADDR_W-1:0] rsv_addr,
  output logic                  rsv_busy,
  regfile_wb_scheduler_if.slave wb,
  input  logic [REG_ADDR_W-1:0] rd_addr0,
  input  logic [REG_ADDR_W-1:0] rd_addr1,
  output logic                  hazard0,
  output logic                  hazard1,
  output logic [NUM_REGS-1:0]   busy
);

  logic [N_REQ-1:0]    gnt;
  logic                transfer;
  wb_req_t             win;
  logic [NUM_REGS-1:1] busy_q;
  logic [NUM_REGS-1:1] busy_next;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (wb.req_valid),
    .advance (transfer),
    .gnt     (gnt)
  );

  // The output stage never stalls, so every grant is a transfer.
  assign wb.req_ready = gnt;
  assign transfer     = |(gnt & wb.req_valid);

  always_comb begin
    win = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        win.addr = wb.req_addr[i*REG_ADDR_W +: REG_ADDR_W];
        win.data = wb.req_data[i*XLEN +: XLEN];
      end
    end
  end

  // Writes to x0 are accepted and acknowledged but never enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb.wr_ena  <= 1'b0;
      wb.wr_addr <= '0;
      wb.wr_data <= '0;
    end else if (transfer) begin
      wb.wr_ena  <= (win.addr != '0);
      wb.wr_addr <= win.addr;
      wb.wr_data <= win.data;
    end else begin
      wb.wr_ena  <= 1'b0;
    end
  end

  // Clear is applied before set so that a new reservation overrides a
  // writeback landing on the same register at the same edge.
  always_comb begin
    busy_next = busy_q;
    if (wb.wr_ena && (wb.wr_addr != '0)) begin
      busy_next[wb.wr_addr] = 1'b0;
    end
    if (rsv_valid && (rsv_addr != '0)) begin
      busy_next[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_next;
    end
  end

  assign busy     = {busy_q, 1'b0};
  assign rsv_busy = busy[rsv_addr];
  assign hazard0  = busy[rd_addr0];
  assign hazard1  = busy[rd_addr1];

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler with a tiny register-file model.
module tb_regfile_wb_scheduler;
  import regfile_pkg::*;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rsv_valid = 1'b0;
  logic [4:0]  rsv_addr = '0;
  logic        rsv_busy;
  logic [4:0]  rd_addr0 = '0;
  logic [4:0]  rd_addr1 = '0;
  logic        hazard0;
  logic        hazard1;
  logic [31:0] busy;

  logic [31:0] rf [32];
  int          checks = 0;
  int          errors = 0;
  logic [2:0]  rr_exp [10];

  regfile_wb_scheduler_if #(.N_REQ(N)) wb ();

  regfile_wb_scheduler #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rsv_busy  (rsv_busy),
    .wb        (wb),
    .rd_addr0  (rd_addr0),
    .rd_addr1  (rd_addr1),
    .hazard0   (hazard0),
    .hazard1   (hazard1),
    .busy      (busy)
  );

  // clock / reset block
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wb.wr_ena) rf[wb.wr_addr] <= wb.wr_data;
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    wb.req_addr[i*5 +: 5]   = a;
    wb.req_data[i*32 +: 32] = d;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    wb.req_valid = '0;
    wb.req_addr  = '0;
    wb.req_data  = '0;
    for (int r = 0; r < 32; r++) rf[r] = '0;
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100,
               3'b001, 3'b100, 3'b001, 3'b100};

    // reset state
    #1 rst = 1'b1;
    #2;
    check("rst_wr_ena", wb.wr_ena, 0);
    check("rst_wr_addr", wb.wr_addr, 0);
    check("rst_wr_data", wb.wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", wb.req_ready, 0);
    #9 rst = 1'b0;
    cyc();

    // reservation and RAW: reserve x5 at t0, requester 1 writes at t3
    rsv_valid = 1'b1; rsv_addr = 5'd5; rd_addr0 = 5'd5;
    @(negedge clk);
    check("raw_t0_hazard", hazard0, 0);
    cyc();
    rsv_valid = 1'b0;
    @(negedge clk);
    check("raw_t1_hazard", hazard0, 1);
    check("raw_t1_rsv_busy", rsv_busy, 1);
    cyc();
    @(negedge clk);
    check("raw_t2_hazard", hazard0, 1);
    cyc();
    set_req(1, 5'd5, 32'hDEADBEEF);
    wb.req_valid = 3'b010;
    @(negedge clk);
    check("raw_t3_ready", wb.req_ready, 3'b010);
    check("raw_t3_hazard", hazard0, 1);
    cyc();
    wb.req_valid = '0;
    @(negedge clk);
    check("raw_t4_wr_ena", wb.wr_ena, 1);
    check("raw_t4_wr_addr", wb.wr_addr, 5);
    check("raw_t4_wr_data", wb.wr_data, 32'hDEADBEEF);
    check("raw_t4_hazard", hazard0, 1);
    cyc();
    @(negedge clk);
    check("raw_t5_hazard", hazard0, 0);
    check("raw_t5_rf", rf[5], 32'hDEADBEEF);
    check("raw_t5_wr_ena", wb.wr_ena, 0);

    // round-robin after reset
    reset_pulse();
    cyc();
    for (int i = 0; i < N; i++) set_req(i, 5'(21 + i), 32'(100 + i));
    wb.req_valid = 3'b111;
    for (int k = 0; k < 10; k++) begin
      if (k == 6) wb.req_valid = 3'b101;
      @(negedge clk);
      check($sformatf("rr_%0d", k), wb.req_ready, rr_exp[k]);
      cyc();
    end
    wb.req_valid = '0;

    // x0 handling (last winner is requester 2)
    rsv_valid = 1'b1; rsv_addr = 5'd0; rd_addr0 = 5'd0;
    set_req(0, 5'd0, 32'h12345678);
    wb.req_valid = 3'b001;
    @(negedge clk);
    check("x0_rsv_busy", rsv_busy, 0);
    check("x0_hazard", hazard0, 0);
    check("x0_ready", wb.req_ready, 3'b001);
    cyc();
    rsv_valid = 1'b0;
    wb.req_valid = '0;
    @(negedge clk);
    check("x0_wr_ena", wb.wr_ena, 0);
    check("x0_wr_data", wb.wr_data, 32'h12345678);
    check("x0_busy0", busy[0], 0);
    check("x0_ready_drop", wb.req_ready, 0);
    cyc();

    // set/clear collision on x7
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    cyc();
    rsv_valid = 1'b0;
    set_req(0, 5'd7, 32'hAA);
    wb.req_valid = 3'b001;
    @(negedge clk);
    check("col_busy_set", busy[7], 1);
    cyc();
    wb.req_valid = '0;
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    @(negedge clk);
    check("col_wr_ena", wb.wr_ena, 1);
    check("col_wr_addr", wb.wr_addr, 7);
    cyc();
    rsv_valid = 1'b0;
    set_req(0, 5'd7, 32'hBB);
    wb.req_valid = 3'b001;
    @(negedge clk);
    check("col_busy_kept", busy[7], 1);
    cyc();
    wb.req_valid = '0;
    @(negedge clk);
    check("col_busy_before_clear", busy[7], 1);
    cyc();
    @(negedge clk);
    check("col_busy_cleared", busy[7], 0);
    cyc();

    // asynchronous reset mid-stream (last winner is requester 0)
    rsv_valid = 1'b1; rsv_addr = 5'd3; rd_addr0 = 5'd3; rd_addr1 = 5'd9;
    cyc();
    rsv_addr = 5'd9;
    set_req(0, 5'd20, 32'h55);
    wb.req_valid = 3'b001;
    cyc();
    rsv_valid = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 5'(21 + i), 32'(200 + i));
    wb.req_valid = 3'b111;
    @(negedge clk);
    check("ar_pre_wr_ena", wb.wr_ena, 1);
    check("ar_pre_busy", busy, 32'h0000_0208);
    check("ar_pre_haz", {hazard1, hazard0}, 2'b11);
    check("ar_pre_ready", wb.req_ready, 3'b010);
    #2 rst = 1'b1;
    #1;
    check("ar_busy", busy, 0);
    check("ar_wr_ena", wb.wr_ena, 0);
    check("ar_haz", {hazard1, hazard0}, 2'b00);
    check("ar_ready", wb.req_ready, 3'b001);
    #1 rst = 1'b0;
    cyc();
    wb.req_valid = '0;
    @(negedge clk);
    check("ar_first_wr_ena", wb.wr_ena, 1);
    check("ar_first_wr_addr", wb.wr_addr, 21);
    cyc();

    // back-to-back writes from requester 2
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        set_req(2, 5'(10 + k), 32'(k + 1));
        wb.req_valid = 3'b100;
      end else begin
        wb.req_valid = '0;
      end
      if (k > 0) begin
        @(negedge clk);
        check($sformatf("b2b_ena_%0d", k), wb.wr_ena, 1);
        check($sformatf("b2b_addr_%0d", k), wb.wr_addr, 32'(9 + k));
        check($sformatf("b2b_data_%0d", k), wb.wr_data, 32'(k));
      end
      cyc();
    end
    @(negedge clk);
    check("b2b_idle", wb.wr_ena, 0);
    check("b2b_rf12", rf[12], 3);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Writeback scheduler for the 32 x 32-bit register file. It shares the file's single write port between `N_REQ` writeback requesters (e.g. ALU, load unit, CSR unit) using round-robin arbitration with valid/ready handshakes. It also keeps a per-register busy scoreboard, set when a destination is reserved at issue and cleared when its writeback lands, and reports read-after-write hazards for the file's two read addresses. It sits between the execute/memory stages and the register file's write channel.

## Interface
- `N_REQ`, default 3: number of writeback requesters (2..8).
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `rsv_valid`  in  1  reserve a destination register this cycle.
- `rsv_addr`  in  5  destination register to mark busy.
- `rsv_busy`  out  1  `busy[rsv_addr]` (combinational); issue logic must not reserve while high.
- `req_valid`  in  `N_REQ`  per-requester writeback request.
- `req_addr`  in  `5*N_REQ`  flattened destination addresses; requester i occupies `[5i+4:5i]`.
- `req_data`  in  `32*N_REQ`  flattened write data; requester i occupies `[32i+31:32i]`.
- `req_ready`  out  `N_REQ`  one-hot grant (combinational); a transfer occurs when `valid & ready`.
- `wr_ena`  out  1  register file write enable (registered).
- `wr_addr`  out  5  register file write address (registered).
- `wr_data`  out  32  register file write data (registered).
- `rd_addr0`, `rd_addr1`  in  5 each  register file read addresses.
- `hazard0`, `hazard1`  out  1 each  the corresponding read address is busy (combinational).

## Operation
- **Arbitration.** Round-robin over requesters with `req_valid` high. The search starts at `last_grant+1` and wraps modulo `N_REQ`.
  - At most one `req_ready` is high per cycle.
  - `req_ready[i]` is low whenever `req_valid[i]` is low.
  - `last_grant` updates only on a transfer.
- **Handshake.** A requester holds `req_valid`, `req_addr` and `req_data` stable until it is granted. `req_valid` must not drop before the grant.
- **Output stage.** The output stage never back-pressures, so one write is accepted every cycle whenever any request is valid.
  - On a transfer, register `wr_addr`/`wr_data` from the winner.
  - `wr_ena` is 1 only if the winner's address is non-zero.
  - A write to x0 is accepted and acknowledged, but `wr_ena` stays 0.
  - With no transfer, `wr_ena` is 0 and `wr_addr`/`wr_data` hold their previous values.
- **Scoreboard.** 32-bit `busy` vector; `busy[0]` is constantly 0.
  - Set: `rsv_valid && rsv_addr != 0` sets `busy[rsv_addr]` at the clock edge.
  - Clear: a registered `wr_ena` clears `busy[wr_addr]` at the edge that ends the cycle in which the file commits the write.
  - Same edge, same address, set and clear: set wins, because the new producer owns the register.
  - Reserving an already-busy register is an issue-logic error. `busy` stays 1 and clears on the first writeback.
  - A writeback to a non-busy register is legal (e.g. from an unreserved producer) and leaves `busy` at 0.
- **Hazards.** `hazardK = busy[rd_addrK]`, which is 0 for address 0. This is a pure lookup with no bypass. The consumer stalls until the hazard drops, then reads the committed value from the file.

## Timing
- Reset values:
  - `busy` = 0.
  - `last_grant` = `N_REQ-1`, so requester 0 wins first.
  - `wr_ena` = 0, `wr_addr` = 0, `wr_data` = 0.
  - `req_ready`, `hazard*` and `rsv_busy` follow from those values.
- Reset asserted mid-operation takes effect immediately, without waiting for a clock edge:
  - clears all busy bits and drops `wr_ena`;
  - in-flight grants are lost, and requesters must re-present after reset.
- Cycle timeline for a single write:
  - Cycle t: grant and transfer.
  - Cycle t+1: `wr_*` driven; the register file writes at the end of t+1, and the busy bit clears at that same edge.
  - Cycle t+2: `hazard` low and the new value readable.
  - Grant-to-readable latency: 2 cycles.
- Throughput: 1 write per cycle.
- Fairness: with all `N_REQ` requesters continuously valid, each is granted exactly once every `N_REQ` cycles.

## Structure
- Shared package `regfile_pkg`: `XLEN = 32`, `REG_ADDR_W = 5`, `NUM_REGS = 32`, and a `wb_req_t` struct `{addr, data}`. The register file and this block both use the package.
- Sub-module `rr_arbiter #(N)`: inputs `req[N]` and `advance`; output one-hot `gnt[N]`; owns `last_grant`; clocked on `clk`/`rst`.
- The top level holds the output register, the scoreboard, and the hazard/`rsv_busy` lookup muxes.

## Test plan
- **Reservation and RAW:** reserve x5 at t0, then requester 1 writes x5 = 0xDEADBEEF at t3.
  - `hazard0` (with `rd_addr0 = 5`) is 1 from t1 through t4.
  - `wr_ena=1`, `wr_addr=5` at t4.
  - `hazard0 = 0` and the file reads 0xDEADBEEF at t5.
- **Round-robin:** all 3 requesters valid for 6 cycles after reset → grant order 0, 1, 2, 0, 1, 2. Requester 1 drops out → order alternates 0, 2, 0, 2.
- **x0 handling:** reserve x0 and request a write to x0 with data 0x12345678.
  - `rsv_busy`, `hazard` and `busy[0]` all stay 0.
  - `req_ready` pulses for one cycle; `wr_ena` stays 0.
- **Set/clear collision:** x7 is busy with its writeback landing at edge E, and `rsv_valid` for x7 arrives in the cycle ending at E → `busy[7]` remains 1 after E.
- **Asynchronous reset mid-stream:** x3 and x9 busy, a grant pending, then pulse `rst` between clock edges.
  - `busy` = 0, `wr_ena` = 0 and `hazard*` = 0 immediately, before any edge.
  - The first grant after release goes to requester 0.
- **Back-to-back writes:** requester 2 writes x10 = 1, x11 = 2, x12 = 3 on consecutive cycles → `wr_ena` high for 3 consecutive cycles with matching addresses and data.
